ctrl_edit_timer: RTL and testbench
==================================

CTRL_EDIT_TIMER -- requirements
Module: ctrl_edit_timer

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 50_000_000, meaning hold time in clk cycles before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_PERIOD, default 10_000_000, meaning clk cycles between auto-repeat pulses.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; the ports are named clk and reset.
REQ-004 SHALL have port clk, input, 1 bit: system clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port btn_edit, input, 1 bit: debounced level; toggles edit mode.
REQ-007 SHALL have port btn_left, input, 1 bit: debounced level; selects the previous field.
REQ-008 SHALL have port btn_right, input, 1 bit: debounced level; selects the next field.
REQ-009 SHALL have port btn_up, input, 1 bit: debounced level; increments the selected field.
REQ-010 SHALL have port btn_down, input, 1 bit: debounced level; decrements the selected field.
REQ-011 SHALL have port en_count, output, 4 bits: field select code for the timer digit counters.
REQ-012 SHALL have port enUP, output, 1 bit: single-cycle increment pulse.
REQ-013 SHALL have port enDOWN, output, 1 bit: single-cycle decrement pulse.
REQ-014 SHALL have port edit_mode, output, 1 bit: high while any field is being edited.

Function
REQ-015 SHALL implement FSM states IDLE, EDIT_HH, EDIT_MM and EDIT_SS.
REQ-016 SHALL drive en_count from state, all outputs registered: IDLE=0, EDIT_HH=10, EDIT_MM=11, EDIT_SS=12.
REQ-017 SHALL drive edit_mode high exactly when state is not IDLE.
REQ-018 SHALL treat an edge as input sampled high at a clk rising edge after being sampled low at the previous edge.
REQ-019 SHALL move IDLE->EDIT_HH on a btn_edit edge, and any EDIT_* state->IDLE on a btn_edit edge.
REQ-020 SHALL step HH->MM->SS->HH on a btn_right edge and HH->SS->MM->HH on a btn_left edge; simultaneous left and right edges SHALL cause no change.
REQ-021 SHALL ignore left, right, up and down in IDLE: no pulses, and en_count stays 0.
REQ-022 SHALL, on a btn_up edge in any EDIT_* state, assert enUP for exactly one cycle, visible in the cycle following the sampling edge (latency 1).
REQ-023 SHALL, while btn_up remains high, pulse enUP again REPEAT_DELAY cycles after the first pulse, then every REPEAT_PERIOD cycles.
REQ-024 SHALL apply REQ-022 and REQ-023 to btn_down/enDOWN identically.
REQ-025 SHALL, when btn_up and btn_down are both high, assert no pulse and clear both repeat counters; a new pulse requires a fresh edge.
REQ-026 SHALL clear both repeat counters on any state change; the held button needs a fresh edge.
REQ-027 SHALL never assert enUP and enDOWN in the same cycle, and SHALL never assert either while en_count=0.
REQ-028 SHALL clear a pending pulse on a btn_edit exit edge: en_count=0 and no enUP/enDOWN from the next cycle.
REQ-029 SHALL size repeat counters to ceil(log2(REPEAT_DELAY+1)) bits (26 at default), saturating with no wrap.

Reset
REQ-030 SHALL, on reset low, asynchronously force state=IDLE, en_count=0, enUP=0, enDOWN=0, edit_mode=0 and repeat counters=0.
REQ-031 SHALL reset the previous-sample registers to 1, so a button held through reset release generates no edge.
REQ-032 SHALL, on reset asserted mid-edit or mid-repeat, abort immediately; no pulse after release until a fresh edge.

Structure
REQ-033 SHALL place the field codes (10/11/12), the IDLE code (0) and the state encoding in shared package timer_edit_pkg.
REQ-034 SHALL implement edge detect plus auto-repeat in sub-module repeat_pulse_gen, instantiated for up and for down with a clear input.

Verification (bench parameters REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-035 SHALL cover: reset low, then a btn_edit edge -> en_count 0->10 and edit_mode=1 one cycle later.
REQ-036 SHALL cover: in EDIT_HH, btn_right edge x3 -> en_count 11, 12, 10; then btn_left edge -> 12.
REQ-037 SHALL cover: btn_up held 20 cycles in EDIT_HH -> enUP pulses at cycles 1, 9, 12, 15, 18 relative to the edge.
REQ-038 SHALL cover: btn_up and btn_down rising together -> no pulses; release btn_down -> no pulse until btn_up re-edges.
REQ-039 SHALL cover: btn_up held in IDLE, or held through reset release -> enUP stays 0.
REQ-040 SHALL cover: btn_down held, btn_edit edge mid-repeat -> en_count=0 next cycle and enDOWN never high afterwards.

Source files
------------

// File: rtl/timer_edit_pkg.sv
`default_nettype none
// ============================================================================
// timer_edit_pkg : state encoding and field select codes for the timer editor
// Rev 1.0
// ============================================================================
package timer_edit_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT_HH = 2'd1,
    EDIT_MM = 2'd2,
    EDIT_SS = 2'd3
  } state_e;

  localparam logic [3:0] CODE_IDLE = 4'd0;
  localparam logic [3:0] CODE_HH   = 4'd10;
  localparam logic [3:0] CODE_MM   = 4'd11;
  localparam logic [3:0] CODE_SS   = 4'd12;

  function automatic logic [3:0] field_code(state_e s);
    case (s)
      EDIT_HH: return CODE_HH;
      EDIT_MM: return CODE_MM;
      EDIT_SS: return CODE_SS;
      default: return CODE_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_edit_timer_if.sv
`default_nettype none
// ============================================================================
// ctrl_edit_timer_if : button levels in, field select and step pulses out
// Rev 1.0
// ============================================================================
interface ctrl_edit_timer_if;

  logic       btn_edit;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       edit_mode;

  modport master (
    output btn_edit, btn_left, btn_right, btn_up, btn_down,
    input  en_count, enUP, enDOWN, edit_mode
  );

  modport slave (
    input  btn_edit, btn_left, btn_right, btn_up, btn_down,
    output en_count, enUP, enDOWN, edit_mode
  );

endinterface
`default_nettype wire

// File: rtl/repeat_pulse_gen.sv
`default_nettype none
// ============================================================================
// repeat_pulse_gen : rising-edge pulse with hold-to-repeat, clearable
// Rev 1.0
// ============================================================================
module repeat_pulse_gen #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic clr,
  output logic pulse
);

  localparam int unsigned CNT_W = (REPEAT_DELAY < 1) ? 1 : $clog2(REPEAT_DELAY + 1);
  localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MAX    = '1;
  localparam logic [CNT_W-1:0] C_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] C_PERIOD = CNT_W'(REPEAT_PERIOD);

  logic             prev_q,   prev_d;
  logic             active_q, active_d;
  logic             rep_q,    rep_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             pulse_q,  pulse_d;

  // cnt_q counts clock edges since the last emitted pulse
  always_comb begin
    prev_d   = btn;
    active_d = active_q;
    rep_d    = rep_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (clr) begin
      active_d = 1'b0;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end else if (btn && !prev_q) begin
      active_d = 1'b1;
      rep_d    = 1'b0;
      cnt_d    = C_ONE;
      pulse_d  = 1'b1;
    end else if (btn && active_q) begin
      if (cnt_q == (rep_q ? C_PERIOD : C_DELAY)) begin
        pulse_d = 1'b1;
        rep_d   = 1'b1;
        cnt_d   = C_ONE;
      end else if (cnt_q != C_MAX) begin
        cnt_d = cnt_q + C_ONE;
      end
    end else begin
      active_d = 1'b0;
      rep_d    = 1'b0;
      cnt_d    = '0;
    end
  end

  // prev_q resets high so a button held through reset is not seen as an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q   <= 1'b1;
      active_q <= 1'b0;
      rep_q    <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      active_q <= active_d;
      rep_q    <= rep_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/ctrl_edit_timer.sv
`default_nettype none
// ============================================================================
// ctrl_edit_timer : edit-mode FSM selecting HH/MM/SS with up/down step pulses
// Rev 1.0
// ============================================================================
module ctrl_edit_timer
  import timer_edit_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  ctrl_edit_timer_if.slave  bus
);

  state_e     state_q, state_d;
  logic       edit_prev_q,  edit_prev_d;
  logic       left_prev_q,  left_prev_d;
  logic       right_prev_q, right_prev_d;
  logic [3:0] en_count_q,   en_count_d;
  logic       edit_mode_q,  edit_mode_d;

  logic edit_edge, left_edge, right_edge, step_right, step_left;
  logic repeat_clr;
  logic up_pulse, down_pulse;

  assign edit_edge  = bus.btn_edit  & ~edit_prev_q;
  assign left_edge  = bus.btn_left  & ~left_prev_q;
  assign right_edge = bus.btn_right & ~right_prev_q;
  assign step_right = right_edge & ~left_edge;
  assign step_left  = left_edge  & ~right_edge;

  always_comb begin
    state_d      = state_q;
    edit_prev_d  = bus.btn_edit;
    left_prev_d  = bus.btn_left;
    right_prev_d = bus.btn_right;
    case (state_q)
      IDLE: begin
        if (edit_edge) state_d = EDIT_HH;
      end
      EDIT_HH: begin
        if (edit_edge)       state_d = IDLE;
        else if (step_right) state_d = EDIT_MM;
        else if (step_left)  state_d = EDIT_SS;
      end
      EDIT_MM: begin
        if (edit_edge)       state_d = IDLE;
        else if (step_right) state_d = EDIT_SS;
        else if (step_left)  state_d = EDIT_HH;
      end
      EDIT_SS: begin
        if (edit_edge)       state_d = IDLE;
        else if (step_right) state_d = EDIT_HH;
        else if (step_left)  state_d = EDIT_MM;
      end
      default: state_d = IDLE;
    endcase
    en_count_d  = field_code(state_d);
    edit_mode_d = (state_d != IDLE);
    // Any state change or chord of up+down forces a fresh edge before stepping
    repeat_clr  = (state_q == IDLE) || (state_d != state_q) ||
                  (bus.btn_up && bus.btn_down);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      edit_prev_q  <= 1'b1;
      left_prev_q  <= 1'b1;
      right_prev_q <= 1'b1;
      en_count_q   <= CODE_IDLE;
      edit_mode_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      edit_prev_q  <= edit_prev_d;
      left_prev_q  <= left_prev_d;
      right_prev_q <= right_prev_d;
      en_count_q   <= en_count_d;
      edit_mode_q  <= edit_mode_d;
    end
  end

  repeat_pulse_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_up_gen (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_up),
    .clr   (repeat_clr),
    .pulse (up_pulse)
  );

  repeat_pulse_gen #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_down_gen (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_down),
    .clr   (repeat_clr),
    .pulse (down_pulse)
  );

  assign bus.en_count  = en_count_q;
  assign bus.edit_mode = edit_mode_q;
  assign bus.enUP      = up_pulse;
  assign bus.enDOWN    = down_pulse;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_edit_timer.sv
`default_nettype none
// ============================================================================
// tb_ctrl_edit_timer : directed scenarios plus random buttons vs. behavioural model
// Rev 1.0
// ============================================================================
module tb_ctrl_edit_timer;

  localparam int DLY = 8;
  localparam int PER = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ctrl_edit_timer_if bus();

  ctrl_edit_timer #(
    .REPEAT_DELAY  (DLY),
    .REPEAT_PERIOD (PER)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: field index (0 idle, 1 HH, 2 MM, 3 SS) and cycles since accepted press
  int m_st;
  int m_up_k, m_dn_k;
  bit m_pe, m_pl, m_pr, m_pu, m_pd;
  int up_seen, dn_seen;
  int up_at[$];

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_of(int s);
    case (s)
      1: return 10;
      2: return 11;
      3: return 12;
      default: return 0;
    endcase
  endfunction

  function automatic bit fires(int k);
    if (k < 0) return 1'b0;
    if (k == 0 || k == DLY) return 1'b1;
    return (k > DLY) && (((k - DLY) % PER) == 0);
  endfunction

  function automatic int hold_next(int k, bit blocked, bit b, bit p);
    if (blocked)       return -1;
    if (b && !p)       return 0;
    if (b && k >= 0)   return k + 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 0; m_up_k = -1; m_dn_k = -1;
    m_pe = 1; m_pl = 1; m_pr = 1; m_pu = 1; m_pd = 1;
  endtask

  task automatic model_edge();
    bit e, l, r, u, d, ee, le, re, blocked;
    int ns;
    e = bus.btn_edit; l = bus.btn_left; r = bus.btn_right;
    u = bus.btn_up;   d = bus.btn_down;
    ee = e && !m_pe; le = l && !m_pl; re = r && !m_pr;
    ns = m_st;
    if (m_st == 0) begin
      if (ee) ns = 1;
    end else if (ee) begin
      ns = 0;
    end else if (re && !le) begin
      ns = (m_st % 3) + 1;
    end else if (le && !re) begin
      ns = (m_st == 1) ? 3 : m_st - 1;
    end
    blocked = (m_st == 0) || (ns != m_st) || (u && d);
    m_up_k = hold_next(m_up_k, blocked, u, m_pu);
    m_dn_k = hold_next(m_dn_k, blocked, d, m_pd);
    m_st = ns;
    m_pe = e; m_pl = l; m_pr = r; m_pu = u; m_pd = d;
  endtask

  task automatic compare_all();
    chk("en_count",  int'(bus.en_count),  code_of(m_st));
    chk("edit_mode", int'(bus.edit_mode), (m_st != 0) ? 1 : 0);
    chk("enUP",      int'(bus.enUP),      int'(fires(m_up_k)));
    chk("enDOWN",    int'(bus.enDOWN),    int'(fires(m_dn_k)));
  endtask

  task automatic step(input bit e, input bit l, input bit r, input bit u, input bit d);
    @(negedge clk);
    bus.btn_edit = e; bus.btn_left = l; bus.btn_right = r;
    bus.btn_up = u;   bus.btn_down = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (bus.enUP)   up_seen++;
    if (bus.enDOWN) dn_seen++;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_en"},   int'(bus.en_count),  0);
    chk({tag, "_mode"}, int'(bus.edit_mode), 0);
    chk({tag, "_up"},   int'(bus.enUP),      0);
    chk({tag, "_dn"},   int'(bus.enDOWN),    0);
  endtask

  // Asynchronous assert between edges; buttons keep their current levels
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0;
    bus.btn_edit = 0; bus.btn_left = 0; bus.btn_right = 0;
    bus.btn_up = 0;   bus.btn_down = 0;
    model_reset();
    #3 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;

    // Enter edit mode
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("enter_hh", int'(bus.en_count), 10);
    step(0, 0, 0, 0, 0);

    // Field navigation
    step(0, 0, 1, 0, 0); chk("right1", int'(bus.en_count), 11);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0); chk("right2", int'(bus.en_count), 12);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0); chk("right3", int'(bus.en_count), 10);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0); chk("left1", int'(bus.en_count), 12);
    step(0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0); chk("left_right_same", int'(bus.en_count), 12);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0); chk("back_to_hh", int'(bus.en_count), 10);
    step(0, 0, 0, 0, 0);

    // Hold up for 20 cycles: pulse cycles relative to the edge
    up_at.delete();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 0);
      if (bus.enUP) up_at.push_back(i + 1);
    end
    chk("rep_count", up_at.size(), 5);
    if (up_at.size() == 5) begin
      chk("rep_c0", up_at[0], 1);
      chk("rep_c1", up_at[1], 9);
      chk("rep_c2", up_at[2], 12);
      chk("rep_c3", up_at[3], 15);
      chk("rep_c4", up_at[4], 18);
    end
    step(0, 0, 0, 0, 0);

    // Chord of up+down, then release down while up stays held
    up_seen = 0; dn_seen = 0;
    for (int i = 0; i < 5; i++)  step(0, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    chk("chord_up", up_seen, 0);
    chk("chord_dn", dn_seen, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("fresh_up", int'(bus.enUP), 1);
    step(0, 0, 0, 0, 0);

    // Up held in IDLE
    step(1, 0, 0, 0, 0); chk("exit_idle", int'(bus.en_count), 0);
    step(0, 0, 0, 0, 0);
    up_seen = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    chk("idle_up", up_seen, 0);

    // Edit held through reset must not enter edit; up held mid-repeat
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 1, 0);
    do_reset();
    up_seen = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
    chk("rst_hold_edit", int'(bus.edit_mode), 0);
    chk("rst_hold_up", up_seen, 0);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    up_seen = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    chk("enter_held_up", up_seen, 0);
    step(0, 0, 0, 0, 0);

    // Down held, edit exit mid-repeat
    step(0, 0, 0, 1, 0); step(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    chk("exit_en", int'(bus.en_count), 0);
    dn_seen = 0;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    chk("exit_no_down", dn_seen, 0);

    // Randomised button activity
    begin
      bit e, l, r, u, d;
      e = 0; l = 0; r = 0; u = 0; d = 0;
      for (int i = 0; i < 900; i++) begin
        if ($urandom_range(0, 24) == 0) e = !e;
        if ($urandom_range(0, 6) == 0)  l = !l;
        if ($urandom_range(0, 6) == 0)  r = !r;
        if ($urandom_range(0, 9) == 0)  u = !u;
        if ($urandom_range(0, 9) == 0)  d = !d;
        step(e, l, r, u, d);
        if (bus.enUP && bus.enDOWN) chk("both_pulses", 1, 0);
        if ((bus.enUP || bus.enDOWN) && bus.en_count == 4'd0) chk("pulse_in_idle", 1, 0);
        if (i % 300 == 299) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
